range_tracker: RTL and testbench

- Parametrised, next-generation range finder for the chip top: tracks running minimum and maximum of a qualified sample stream over a measurement session.
- Result selectable as range (max-min), max, min or sample count.
- Session end: explicit finish or automatic end after a programmed sample count (window).
- Sticky protocol error flag; synchronous abort without a result.

---
 rtl/range_tracker_if.sv | 31 +++
 rtl/range_tracker.sv | 136 +++++++++++++
 tb/tb_range_tracker.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/range_tracker_if.sv
// Sample-stream and result bundle for range_tracker.
// The master drives the samples and session controls; the slave returns results.
interface range_tracker_if #(
  parameter int WIDTH     = 12,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     data_in;
  logic                 data_valid;
  logic                 go;
  logic                 finish;
  logic                 clear;
  logic [CNT_WIDTH-1:0] window_len;
  logic [1:0]           mode;
  logic [WIDTH:0]       result;
  logic                 result_valid;
  logic                 busy;
  logic [CNT_WIDTH-1:0] count;
  logic                 error;

  modport master (
    output data_in, data_valid, go, finish, clear,
    output window_len, mode,
    input  result, result_valid, busy, count, error
  );

  modport slave (
    input  data_in, data_valid, go, finish, clear,
    input  window_len, mode,
    output result, result_valid, busy, count, error
  );
endinterface

// File: rtl/range_tracker.sv
// Session-based min/max/range/count tracker over a qualified sample stream.
// A result pulse follows each session end; protocol errors are sticky.
module range_tracker #(
  parameter int WIDTH     = 12,
  parameter int CNT_WIDTH = 8,
  parameter bit SIGNED    = 1'b0
) (
  input logic           clock,
  input logic           reset_n,
  range_tracker_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  state_t state, state_n;

  logic [WIDTH-1:0]     mn, mx, mn_n, mx_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0] win_q, win;
  logic [1:0]           mode_q, md;
  logic [WIDTH:0]       res, res_n;
  logic                 rvld, err, err_set;
  logic                 start, act, samp, first, sat;
  logic                 wend, term, zero;

  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] x);
    ext = {SIGNED & x[WIDTH-1], x};
  endfunction

  function automatic logic lt(input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
    lt = $signed(ext(a)) < $signed(ext(b));
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    start   = 1'b0;
    act     = 1'b0;
    samp    = 1'b0;
    first   = 1'b0;
    sat     = 1'b0;
    wend    = 1'b0;
    term    = 1'b0;
    zero    = 1'b0;
    err_set = 1'b0;
    cnt_n   = cnt;
    mn_n    = mn;
    mx_n    = mx;
    win     = win_q;
    md      = mode_q;
    res_n   = '0;
    state_n = state;

    start = (state == IDLE) && bus.go;
    act   = (state == ACTIVE);
    samp  = bus.data_valid && (start || act);
    first = samp && (start || cnt == '0);
    sat   = act && (cnt == CMAX);

    if (start) begin
      win = bus.window_len;
      md  = bus.mode;
    end

    if (start)              cnt_n = CNT_WIDTH'(bus.data_valid);
    else if (samp && !sat)  cnt_n = cnt + 1'b1;

    if (first) begin
      mn_n = bus.data_in;
      mx_n = bus.data_in;
    end else if (samp) begin
      if (lt(bus.data_in, mn)) mn_n = bus.data_in;
      if (lt(mx, bus.data_in)) mx_n = bus.data_in;
    end

    wend = samp && (win != '0) && (cnt_n == win);
    term = (start || act) && (bus.finish || wend);
    zero = term && (cnt_n == '0);

    err_set = (act && bus.go)
            || ((state == IDLE) && !bus.go && bus.finish)
            || zero
            || (samp && sat);

    unique case (md)
      2'b00:   res_n = ext(mx_n) - ext(mn_n);
      2'b01:   res_n = ext(mx_n);
      2'b10:   res_n = ext(mn_n);
      default: res_n = (WIDTH+1)'(cnt_n);
    endcase
    if (zero) res_n = '0;

    if (bus.clear)  state_n = IDLE;
    else if (term)  state_n = IDLE;
    else if (start) state_n = ACTIVE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mn     <= '0;
      mx     <= '0;
      cnt    <= '0;
      win_q  <= '0;
      mode_q <= 2'b00;
      res    <= '0;
      rvld   <= 1'b0;
      err    <= 1'b0;
    end else if (bus.clear) begin
      cnt  <= '0;
      rvld <= 1'b0;
      err  <= 1'b0;
    end else begin
      mn     <= mn_n;
      mx     <= mx_n;
      cnt    <= cnt_n;
      win_q  <= win;
      mode_q <= md;
      rvld   <= term;
      err    <= err | err_set;
      if (term) res <= res_n;
    end
  end

  assign bus.result       = res;
  assign bus.result_valid = rvld;
  assign bus.busy         = (state == ACTIVE);
  assign bus.count        = cnt;
  assign bus.error        = err;

endmodule

// File: tb/tb_range_tracker.sv
// Scoreboard bench for range_tracker in unsigned, signed and narrow-count builds.
// Expected results are queued at stimulus time and popped on result_valid.
module tb_range_tracker;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [12:0] q0[$];
  logic [12:0] q1[$];
  logic [12:0] q2[$];

  range_tracker_if #(.WIDTH(12), .CNT_WIDTH(8)) a0 ();
  range_tracker_if #(.WIDTH(12), .CNT_WIDTH(8)) a1 ();
  range_tracker_if #(.WIDTH(12), .CNT_WIDTH(2)) a2 ();

  range_tracker #(.WIDTH(12), .CNT_WIDTH(8), .SIGNED(1'b0)) u0 (
    .clock(clock), .reset_n(reset_n), .bus(a0.slave));
  range_tracker #(.WIDTH(12), .CNT_WIDTH(8), .SIGNED(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .bus(a1.slave));
  range_tracker #(.WIDTH(12), .CNT_WIDTH(2), .SIGNED(1'b0)) u2 (
    .clock(clock), .reset_n(reset_n), .bus(a2.slave));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (a0.result_valid) begin
      if (q0.size() == 0) chk("u0_extra_pulse", 1, 0);
      else chk("u0_result", 32'(a0.result), 32'(q0.pop_front()));
    end
    if (a1.result_valid) begin
      if (q1.size() == 0) chk("u1_extra_pulse", 1, 0);
      else chk("u1_result", 32'(a1.result), 32'(q1.pop_front()));
    end
    if (a2.result_valid) begin
      if (q2.size() == 0) chk("u2_extra_pulse", 1, 0);
      else chk("u2_result", 32'(a2.result), 32'(q2.pop_front()));
    end
  end

  task automatic idle0();
    a0.data_valid = 0; a0.go = 0; a0.finish = 0; a0.clear = 0;
  endtask

  initial begin
    a0.data_in = 0; a0.window_len = 0; a0.mode = 0;
    a1.data_in = 0; a1.window_len = 0; a1.mode = 0;
    a2.data_in = 0; a2.window_len = 0; a2.mode = 0;
    a1.data_valid = 0; a1.go = 0; a1.finish = 0; a1.clear = 0;
    a2.data_valid = 0; a2.go = 0; a2.finish = 0; a2.clear = 0;
    idle0();
    #12;
    chk("rst_result", 32'(a0.result), 0);
    chk("rst_busy", 32'(a0.busy), 0);
    chk("rst_count", 32'(a0.count), 0);
    chk("rst_error", 32'(a0.error), 0);
    chk("rst_rvld", 32'(a0.result_valid), 0);
    reset_n = 1;
    step();

    // range over 100, 50, 4000, 7
    a0.mode = 2'b00; a0.window_len = 0;
    a0.go = 1; a0.data_valid = 1; a0.data_in = 100;
    step();
    a0.go = 0;
    a0.data_in = 50;   step();
    a0.data_in = 4000; step();
    a0.data_in = 7;    step();
    a0.data_valid = 0; a0.finish = 1;
    q0.push_back(13'd3993);
    step();
    chk("t1_rvld", 32'(a0.result_valid), 1);
    idle0();
    step();
    chk("t1_rvld_low", 32'(a0.result_valid), 0);
    chk("t1_busy", 32'(a0.busy), 0);
    chk("t1_count", 32'(a0.count), 4);

    // signed min, finish with last sample
    a1.mode = 2'b10;
    a1.go = 1; a1.data_valid = 1; a1.data_in = 12'hFFB;
    step();
    a1.go = 0; a1.data_in = 12'h003; step();
    a1.data_in = 12'hF9C; a1.finish = 1;
    q1.push_back(13'h1F9C);
    step();
    a1.data_valid = 0; a1.finish = 0;
    chk("t2_rvld", 32'(a1.result_valid), 1);
    chk("t2_count", 32'(a1.count), 3);

    // auto-finish after 3 samples, count mode
    a0.mode = 2'b11; a0.window_len = 3;
    a0.go = 1; a0.data_valid = 1; a0.data_in = 11;
    step();
    a0.go = 0; a0.data_in = 12; step();
    a0.data_in = 13;
    q0.push_back(13'd3);
    step();
    chk("t3_rvld", 32'(a0.result_valid), 1);
    a0.data_in = 14; step();
    chk("t3_busy", 32'(a0.busy), 0);
    chk("t3_count", 32'(a0.count), 3);
    idle0();
    step();

    // zero-sample finish then clear
    a0.mode = 2'b00; a0.window_len = 0;
    a0.go = 1; step();
    a0.go = 0; a0.finish = 1;
    q0.push_back(13'd0);
    step();
    idle0();
    chk("t4_error", 32'(a0.error), 1);
    chk("t4_rvld", 32'(a0.result_valid), 1);
    a0.clear = 1; step();
    idle0();
    chk("t4_clr_error", 32'(a0.error), 0);
    chk("t4_clr_count", 32'(a0.count), 0);

    // finish in idle: error, no pulse
    a0.finish = 1; step();
    idle0();
    chk("t5_idle_fin_err", 32'(a0.error), 1);
    chk("t5_idle_fin_rvld", 32'(a0.result_valid), 0);
    a0.clear = 1; step();
    idle0();

    // go while active
    a0.go = 1; a0.data_valid = 1; a0.data_in = 10; step();
    a0.go = 1; a0.data_in = 20; step();
    idle0();
    chk("t5_go_busy", 32'(a0.busy), 1);
    a0.finish = 1;
    q0.push_back(13'd10);
    step();
    idle0();
    chk("t5_go_err", 32'(a0.error), 1);
    step();

    // async reset mid-session
    a0.go = 1; a0.data_valid = 1; a0.data_in = 5; step();
    a0.go = 0; a0.data_in = 9; step();
    idle0();
    #2 reset_n = 0;
    #1;
    chk("t6_busy", 32'(a0.busy), 0);
    chk("t6_count", 32'(a0.count), 0);
    chk("t6_error", 32'(a0.error), 0);
    chk("t6_result", 32'(a0.result), 0);
    chk("t6_rvld", 32'(a0.result_valid), 0);
    step();
    reset_n = 1;
    step();
    a0.go = 1; a0.data_valid = 1; a0.data_in = 30; step();
    a0.go = 0; a0.data_in = 10; step();
    a0.data_valid = 0; a0.finish = 1;
    q0.push_back(13'd20);
    step();
    idle0();
    step();

    // narrow counter saturation
    a2.mode = 2'b00;
    a2.go = 1; a2.data_valid = 1; a2.data_in = 200; step();
    a2.go = 0;
    a2.data_in = 100; step();
    a2.data_in = 900; step();
    chk("t7_no_err_yet", 32'(a2.error), 0);
    a2.data_in = 50;  step();
    a2.data_in = 60;  step();
    a2.data_valid = 0; a2.finish = 1;
    q2.push_back(13'd850);
    step();
    a2.finish = 0;
    chk("t7_count", 32'(a2.count), 3);
    chk("t7_error", 32'(a2.error), 1);
    step();
    step();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
